// File: rtl/cache_write_through_buffer.sv
// Write-through store buffer: a circular queue of {addr, wdata, wstrb} that
// presents its head to the AXI write channel through registered outputs.
module cache_write_through_buffer #(
  parameter int CACHE_FRONTEND_ADDR_W = 32,
  parameter int CACHE_FRONTEND_DATA_W = 32,
  parameter int CACHE_FRONTEND_NBYTES = CACHE_FRONTEND_DATA_W / 8,
  parameter int CACHE_FRONTEND_BYTE_W = $clog2(CACHE_FRONTEND_NBYTES),
  parameter int CACHE_WTBUF_DEPTH_W   = 2
) (
  input  logic                                             ap_clk,
  input  logic                                             reset,
  input  logic                                             push,
  input  logic [CACHE_FRONTEND_ADDR_W-CACHE_FRONTEND_BYTE_W-1:0] push_addr,
  input  logic [CACHE_FRONTEND_DATA_W-1:0]                 push_wdata,
  input  logic [CACHE_FRONTEND_NBYTES-1:0]                 push_wstrb,
  output logic                                             full,
  output logic                                             empty,
  output logic [CACHE_WTBUF_DEPTH_W:0]                     level,
  output logic                                             overflow,
  output logic                                             valid,
  output logic [CACHE_FRONTEND_ADDR_W-CACHE_FRONTEND_BYTE_W-1:0] addr,
  output logic [CACHE_FRONTEND_DATA_W-1:0]                 wdata,
  output logic [CACHE_FRONTEND_NBYTES-1:0]                 wstrb,
  input  logic                                             ready
);

  localparam int unsigned AW    = CACHE_FRONTEND_ADDR_W - CACHE_FRONTEND_BYTE_W;
  localparam int unsigned DEPTH = 2 ** CACHE_WTBUF_DEPTH_W;

  logic [AW-1:0]                    mem_addr  [DEPTH];
  logic [CACHE_FRONTEND_DATA_W-1:0] mem_wdata [DEPTH];
  logic [CACHE_FRONTEND_NBYTES-1:0] mem_wstrb [DEPTH];

  logic [CACHE_WTBUF_DEPTH_W-1:0] wptr;
  logic [CACHE_WTBUF_DEPTH_W-1:0] rptr;
  logic [CACHE_WTBUF_DEPTH_W:0]   level_q;
  logic                           push_en;
  logic                           pop_en;

  // Status is derived only from the level register; push/ready never reach it.
  always_comb begin
    level   = level_q;
    full    = (level_q == (CACHE_WTBUF_DEPTH_W+1)'(DEPTH));
    empty   = (level_q == '0);
    valid   = ~empty;
    push_en = push & ~full;
    pop_en  = ready & ~empty;
  end

  // Array contents need no reset.
  always_ff @(posedge ap_clk) begin
    if (push_en) begin
      mem_addr[wptr]  <= push_addr;
      mem_wdata[wptr] <= push_wdata;
      mem_wstrb[wptr] <= push_wstrb;
    end
  end

  always_ff @(posedge ap_clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      wstrb    <= '0;
    end else begin
      if (push & full)
        overflow <= 1'b1;
      if (push_en)
        wptr <= wptr + 1'b1;
      if (pop_en) begin
        rptr  <= rptr + 1'b1;
        addr  <= mem_addr[rptr];
        wdata <= mem_wdata[rptr];
        wstrb <= mem_wstrb[rptr];
      end
      if (push_en && !pop_en)
        level_q <= level_q + 1'b1;
      else if (pop_en && !push_en)
        level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_write_through_buffer.sv
// Directed table-driven bench for cache_write_through_buffer (depth 4).
module tb_cache_write_through_buffer;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int LW = 3;

  logic          ap_clk = 1'b0;
  logic          reset;
  logic          push;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_wdata;
  logic [NB-1:0] push_wstrb;
  logic          full, empty, overflow, valid, ready;
  logic [LW-1:0] level;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [NB-1:0] wstrb;

  int checks = 0;
  int errors = 0;

  cache_write_through_buffer #(
    .CACHE_FRONTEND_ADDR_W(32),
    .CACHE_FRONTEND_DATA_W(32),
    .CACHE_WTBUF_DEPTH_W  (2)
  ) dut (
    .ap_clk    (ap_clk),
    .reset     (reset),
    .push      (push),
    .push_addr (push_addr),
    .push_wdata(push_wdata),
    .push_wstrb(push_wstrb),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .valid     (valid),
    .addr      (addr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .ready     (ready)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic          push;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NB-1:0] s;
    logic          rdy;
    int            lvl;
    logic          ovf;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [NB-1:0] es;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [NB-1:0] s, input logic r, input int lvl, input logic ovf,
                     input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic [NB-1:0] es);
    vec_t v;
    v.push = p; v.a = a; v.d = d; v.s = s; v.rdy = r;
    v.lvl = lvl; v.ovf = ovf; v.ea = ea; v.ed = ed; v.es = es;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int lvl, input logic ovf,
                       input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic [NB-1:0] es);
    logic e_full, e_empty;
    e_full  = (lvl == 4);
    e_empty = (lvl == 0);
    checks++;
    if (level !== LW'(lvl) || full !== e_full || empty !== e_empty || valid !== ~e_empty ||
        overflow !== ovf || addr !== ea || wdata !== ed || wstrb !== es) begin
      errors++;
      $display("FAIL %s: got lvl=%0d full=%b empty=%b valid=%b ovf=%b addr=%h wdata=%h wstrb=%h; want lvl=%0d full=%b empty=%b valid=%b ovf=%b addr=%h wdata=%h wstrb=%h",
               name, level, full, empty, valid, overflow, addr, wdata, wstrb,
               lvl, e_full, e_empty, ~e_empty, ovf, ea, ed, es);
    end
  endtask

  task automatic step(input logic p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] s, input logic r);
    @(negedge ap_clk);
    push = p; push_addr = a; push_wdata = d; push_wstrb = s; ready = r;
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    // Single entry round trip
    add(1, 'h100, 'hAAAA_0001, 'hF, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 'h100, 'hAAAA_0001, 'hF);
    add(0, 0, 0, 0, 0, 0, 0, 'h100, 'hAAAA_0001, 'hF);
    // Fill to depth, then overflow
    add(1, 'h201, 'h1111_0001, 'h1, 0, 1, 0, 'h100, 'hAAAA_0001, 'hF);
    add(1, 'h202, 'h1111_0002, 'h3, 0, 2, 0, 'h100, 'hAAAA_0001, 'hF);
    add(1, 'h203, 'h1111_0003, 'h7, 0, 3, 0, 'h100, 'hAAAA_0001, 'hF);
    add(1, 'h204, 'h1111_0004, 'hF, 0, 4, 0, 'h100, 'hAAAA_0001, 'hF);
    add(1, 'h205, 'h1111_0005, 'h5, 0, 4, 1, 'h100, 'hAAAA_0001, 'hF);
    // Push while full with pop: push still dropped
    add(1, 'h206, 'h1111_0006, 'h6, 1, 3, 1, 'h201, 'h1111_0001, 'h1);
    add(0, 0, 0, 0, 1, 2, 1, 'h202, 'h1111_0002, 'h3);
    add(0, 0, 0, 0, 1, 1, 1, 'h203, 'h1111_0003, 'h7);
    add(0, 0, 0, 0, 1, 0, 1, 'h204, 'h1111_0004, 'hF);
    // Level 1: simultaneous push and pop
    add(1, 'h301, 'h3000_0001, 'h9, 0, 1, 1, 'h204, 'h1111_0004, 'hF);
    add(1, 'h302, 'h3000_0002, 'hC, 1, 1, 1, 'h301, 'h3000_0001, 'h9);
    add(0, 0, 0, 0, 1, 0, 1, 'h302, 'h3000_0002, 'hC);
    // Ten entries streamed with pointer wrap
    add(1, 'h401, 'h4000_0001, 'h1, 0, 1, 1, 'h302, 'h3000_0002, 'hC);
    add(1, 'h402, 'h4000_0002, 'h2, 0, 2, 1, 'h302, 'h3000_0002, 'hC);
    for (int n = 3; n <= 10; n++)
      add(1, AW'('h400 + n), DW'('h4000_0000 + n), NB'(n), 1, 2, 1,
          AW'('h400 + n - 2), DW'('h4000_0000 + n - 2), NB'(n - 2));
    add(0, 0, 0, 0, 1, 1, 1, 'h409, 'h4000_0009, 'h9);
    add(0, 0, 0, 0, 1, 0, 1, 'h40A, 'h4000_000A, 'hA);

    push = 0; push_addr = '0; push_wdata = '0; push_wstrb = '0; ready = 0;
    reset = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    check("reset", 0, 0, 0, 0, 0);
    @(negedge ap_clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].push, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].ovf, vecs[i].ea, vecs[i].ed, vecs[i].es);
    end

    // Ready held while empty: nothing moves
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 0, 1);
      check($sformatf("empty_ready%0d", c), 0, 1, 'h40A, 'h4000_000A, 'hA);
    end

    // Asynchronous reset mid-cycle with level 3
    step(1, 'h501, 'h5000_0001, 'h1, 0);
    step(1, 'h502, 'h5000_0002, 'h2, 0);
    step(1, 'h503, 'h5000_0003, 'h3, 0);
    check("pre_reset", 3, 1, 'h40A, 'h4000_000A, 'hA);
    @(negedge ap_clk);
    push = 0; ready = 0;
    #2 reset = 1'b1;
    #1 check("async_reset", 0, 0, 0, 0, 0);
    @(negedge ap_clk);
    reset = 1'b0;
    step(1, 'h601, 'h6000_0001, 'hE, 0);
    check("post_reset_push", 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("post_reset_pop", 0, 0, 'h601, 'h6000_0001, 'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
